// File: rtl/bcd4_to_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the converter state encoding and the digit/width constants
// used by the top, the multiply-accumulate stage and the interface.
package bcd4_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam int         NUM_DIGITS = 4;
  localparam int         VALUE_W    = 14;

endpackage

// File: rtl/bcd4_to_bin_if.sv
// Handshake/data bundle between a requester and bcd4_to_bin.
// Ports: start, A (ones), B (tens), C (hundreds), D (thousands) from master;
//        value, done, busy, err returned by the converter (slave).
interface bcd4_to_bin_if;
  import bcd4_to_bin_pkg::*;

  logic               start;
  logic [3:0]         A;
  logic [3:0]         B;
  logic [3:0]         C;
  logic [3:0]         D;
  logic [VALUE_W-1:0] value;
  logic               done;
  logic               busy;
  logic               err;

  modport master (
    output start, A, B, C, D,
    input  value, done, busy, err
  );

  modport slave (
    input  start, A, B, C, D,
    output value, done, busy, err
  );
endinterface

// File: rtl/bcd4_to_bin_bcd_mac10.sv
// One decimal step of the conversion: result = acc*10 + digit.
// Ports: acc, digit in; result (truncated to VALUE_W), illegal (digit > 9),
//        ovf (truncated product bits were non-zero) out. Purely combinational.
module bcd_mac10
  import bcd4_to_bin_pkg::*;
(
  input  logic [VALUE_W-1:0] acc,
  input  logic [3:0]         digit,
  output logic [VALUE_W-1:0] result,
  output logic               illegal,
  output logic               ovf
);
  localparam int PROD_W = 17;

  logic [PROD_W-1:0] acc_w;
  logic [PROD_W-1:0] wide;

  // x10 as x8 + x2, evaluated wide so the shifts never lose bits
  assign acc_w   = PROD_W'(acc);
  assign wide    = (acc_w << 3) + (acc_w << 1) + PROD_W'(digit);
  assign result  = wide[VALUE_W-1:0];
  assign ovf     = |wide[PROD_W-1:VALUE_W];
  assign illegal = (digit > DIGIT_MAX);
endmodule

// File: rtl/bcd4_to_bin.sv
// Converts four BCD digits (D..A, thousands..ones) to a 14-bit binary value.
// Ports: clk, rst (async active-low), bus (slave): start/A..D in; value/done/busy/err out.
// Fixed 5-cycle latency; start ignored while busy or finishing. Optional
// BCD4_TO_BIN_LEADING_BLANK_EN lets leading BLANK_CODE digits count as 0.
module bcd4_to_bin
  import bcd4_to_bin_pkg::*;
#(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  bcd4_to_bin_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_t             state;
  logic [3:0]         dig [NUM_DIGITS];
  logic [VALUE_W-1:0] acc;
  logic [IDX_W-1:0]   idx;
  logic               err_acc;

  logic [3:0]         cur;
  logic [3:0]         mac_digit;
  logic [VALUE_W-1:0] mac_acc;
  logic               mac_illegal;
  logic               mac_ovf;
  logic               blank_err;

  assign cur = dig[idx];

`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
  // leading stays set only while every digit seen so far was blank
  logic leading;
  logic lead_blank;

  assign lead_blank = leading && (cur == BLANK_CODE);
  assign mac_digit  = lead_blank ? 4'd0 : cur;
  assign blank_err  = !leading && (cur == BLANK_CODE);
`else
  // blank is always illegal; checked explicitly in case BLANK_CODE <= 9
  assign mac_digit  = cur;
  assign blank_err  = (cur == BLANK_CODE);
`endif

  bcd_mac10 u_mac (
    .acc     (acc),
    .digit   (mac_digit),
    .result  (mac_acc),
    .illegal (mac_illegal),
    .ovf     (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= IDX_W'(NUM_DIGITS - 1);
      err_acc   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
      leading   <= 1'b1;
`endif
      bus.value <= '0;
      bus.done  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dig[3]   <= bus.D;
            dig[2]   <= bus.C;
            dig[1]   <= bus.B;
            dig[0]   <= bus.A;
            acc      <= '0;
            idx      <= IDX_W'(NUM_DIGITS - 1);
            err_acc  <= 1'b0;
`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
            leading  <= 1'b1;
`endif
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          acc     <= mac_acc;
          // ovf cannot fire for legal digits; kept as a guard on the truncation
          err_acc <= err_acc | mac_illegal | mac_ovf | blank_err;
`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
          leading <= lead_blank;
`endif
          idx     <= idx - 1'b1;
          if (idx == '0) state <= FIN;
        end
        FIN: begin
          bus.value <= err_acc ? '0 : acc;
          bus.err   <= err_acc;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd4_to_bin.sv
// Self-checking bench for bcd4_to_bin: directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_bcd4_to_bin;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  bcd4_to_bin_if bus ();

  bcd4_to_bin #(.BLANK_CODE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain decimal arithmetic, returns {err, value}
  function automatic logic [14:0] ref_conv(input logic [3:0] d3, input logic [3:0] d2,
                                           input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] dg [4];
    int v;
    bit e;
    bit lead;
    dg = '{d3, d2, d1, d0};
    v = 0;
    e = 0;
    lead = 1;
    for (int i = 0; i < 4; i++) begin
      int x;
      x = int'(dg[i]);
`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
      if (lead && dg[i] == 4'hF) x = 0;
      else lead = 0;
`else
      lead = 0;
`endif
      if (x > 9) e = 1;
      v = v * 10 + x;
    end
    if (lead) e = 0;
    return {e, e ? 14'd0 : 14'(v)};
  endfunction

  // Cycle model: counts down the fixed latency from an accepted start
  int          m_cnt = 0;
  logic [14:0] m_res = '0;
  logic [13:0] m_value = '0;
  logic        m_err = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_value <= '0;
      m_err   <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          m_res <= ref_conv(bus.D, bus.C, bus.B, bus.A);
          m_cnt <= 5;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_value <= m_res[13:0];
          m_err   <= m_res[14];
          m_done  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_value", 32'(bus.value), 32'(m_value));
    check("cmp_err",   32'(bus.err),   32'(m_err));
    check("cmp_done",  32'(bus.done),  32'(m_done));
    check("cmp_busy",  32'(bus.busy),  32'(m_cnt != 0));
  end

  task automatic set_digits(input logic [3:0] d, input logic [3:0] c,
                            input logic [3:0] b, input logic [3:0] a);
    bus.D = d; bus.C = c; bus.B = b; bus.A = a;
  endtask

  // Leaves the caller at the negedge just after the sampling edge (edge 0)
  task automatic start_pulse(input logic [3:0] d, input logic [3:0] c,
                             input logic [3:0] b, input logic [3:0] a);
    @(negedge clk);
    set_digits(d, c, b, a);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (cyc < max) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic run_conv(input string name, input logic [3:0] d, input logic [3:0] c,
                          input logic [3:0] b, input logic [3:0] a,
                          input int exp_v, input logic exp_e);
    int cyc;
    start_pulse(d, c, b, a);
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(10, cyc);
    check({name, "_lat"},   32'(cyc), 32'd5);
    check({name, "_value"}, 32'(bus.value), 32'(exp_v));
    check({name, "_err"},   32'(bus.err), 32'(exp_e));
    check({name, "_nbusy"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({name, "_done1"}, 32'(bus.done), 32'd0);
  endtask

  function automatic logic [3:0] rand_digit();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return 4'($urandom_range(0, 9));
    if (r == 7) return 4'hF;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    int cyc;
    int dn;
    bus.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    rst = 1'b0;

    // Model pinned by hand-computed results
    check("model_1234", 32'(ref_conv(4'd1, 4'd2, 4'd3, 4'd4)), 32'd1234);
    check("model_9999", 32'(ref_conv(4'd9, 4'd9, 4'd9, 4'd9)), 32'd9999);
    check("model_4F01", 32'(ref_conv(4'd4, 4'hF, 4'd0, 4'd1)), 32'h4000);
`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
    check("model_FF42", 32'(ref_conv(4'hF, 4'hF, 4'd4, 4'd2)), 32'd42);
`else
    check("model_FF42", 32'(ref_conv(4'hF, 4'hF, 4'd4, 4'd2)), 32'h4000);
`endif

    repeat (2) @(negedge clk);
    check("rst_value", 32'(bus.value), 32'd0);
    check("rst_flags", 32'({bus.done, bus.busy, bus.err}), 32'd0);

    // First start on the very first edge after release
    @(negedge clk);
    rst = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_busy", 32'(bus.busy), 32'd1);
    wait_done(10, cyc);
    check("first_lat", 32'(cyc), 32'd5);
    check("first_value", 32'(bus.value), 32'd1234);
    check("first_err", 32'(bus.err), 32'd0);

    run_conv("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0);
    run_conv("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    run_conv("cA",    4'd0, 4'd0, 4'd0, 4'hA, 0, 1'b1);
    run_conv("c0042", 4'd0, 4'd0, 4'd4, 4'd2, 42, 1'b0);
`ifdef BCD4_TO_BIN_LEADING_BLANK_EN
    run_conv("cFF42", 4'hF, 4'hF, 4'd4, 4'd2, 42, 1'b0);
    run_conv("cFFFF", 4'hF, 4'hF, 4'hF, 4'hF, 0, 1'b0);
`else
    run_conv("cFF42", 4'hF, 4'hF, 4'd4, 4'd2, 0, 1'b1);
`endif
    run_conv("c4F01", 4'd4, 4'hF, 4'd0, 4'd1, 0, 1'b1);

    // Restarts at edges 2 and 5 with changed digits are ignored
    start_pulse(4'd1, 4'd2, 4'd3, 4'd4);
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    dn = 0;
    for (int e = 1; e <= 12; e++) begin
      bus.start = (e == 2 || e == 5);
      @(negedge clk);
      if (bus.done) begin
        dn++;
        check("restart_value", 32'(bus.value), 32'd1234);
        check("restart_edge", 32'(e), 32'd5);
      end
    end
    bus.start = 1'b0;
    check("restart_ndone", 32'(dn), 32'd1);

    // Reset at edge 3 aborts the conversion
    start_pulse(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outs", 32'({bus.value, bus.done, bus.busy, bus.err}), 32'd0);
    #1 rst = 1'b1;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_ndone", 32'(dn), 32'd0);
    run_conv("after_abort", 4'd0, 4'd0, 4'd0, 4'd5, 5, 1'b0);

    // Random traffic: digits, starts and occasional resets
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      bus.start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/bcd4_to_bin.md
BCD4_TO_BIN -- requirements
Module: bcd4_to_bin

Interface
REQ-001 SHALL have parameter: BLANK_CODE, default 4'hF, digit code meaning "blank/unlit".
REQ-002 SHALL have port: clk  input  1  clock, rising-edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  conversion request, sampled on clk rising edge.
REQ-005 SHALL have port: A  input  4  BCD ones digit.
REQ-006 SHALL have port: B  input  4  BCD tens digit.
REQ-007 SHALL have port: C  input  4  BCD hundreds digit.
REQ-008 SHALL have port: D  input  4  BCD thousands digit.
REQ-009 SHALL have port: value  output  14  binary result, registered, 0..9999.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: busy  output  1  conversion in progress.
REQ-012 SHALL have port: err  output  1  last conversion had an illegal digit, registered.

Function
REQ-013 SHALL use a state machine with states IDLE, CONV and FIN.
REQ-014 In IDLE, start=1 SHALL capture A..D into internal registers, clear the accumulator to 0, set the digit index to 3 (D), set busy=1 and go to CONV.
REQ-015 In CONV, each cycle SHALL compute acc = acc*10 + digit[index], with *10 done as (acc<<3)+(acc<<1), then decrement the index; after index 0 it SHALL go to FIN.
REQ-016 In FIN, the block SHALL load value with acc (or 0 when err is set), set done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-017 Latency SHALL be fixed: start is sampled at edge 0, value, err and done update at edge 5, and busy is high from after edge 0 until edge 5.
REQ-018 Input digits SHALL be sampled only at edge 0; later changes on A..D SHALL NOT affect the current conversion.
REQ-019 start while busy=1 SHALL be ignored, with no queueing; start in the FIN cycle SHALL also be ignored.
REQ-020 Any digit code 10..14 SHALL set err=1 for that conversion.
REQ-021 BLANK_CODE handling SHALL follow REQ-027/REQ-028.
REQ-022 value, err SHALL hold their values between conversions; done SHALL be 0 except in the FIN-completion cycle.
REQ-023 The accumulator SHALL be 14 bits wide, with intermediate *10 products computed at 17 bits and truncated to 14 bits; legal inputs never overflow.

Reset
REQ-024 rst=0 SHALL asynchronously force state=IDLE, value=0, done=0, busy=0, err=0, accumulator=0 and index=3.
REQ-025 Reset during CONV or FIN SHALL abort the conversion with no done pulse; after release, the block SHALL be in IDLE.
REQ-026 The first start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-027 With macro BCD4_TO_BIN_LEADING_BLANK_EN defined: BLANK_CODE digits that are leading (all more-significant digits also BLANK_CODE) SHALL be treated as 0; a non-leading BLANK_CODE digit SHALL set err; an all-blank input SHALL give value=0, err=0.
REQ-028 Without the macro, BLANK_CODE SHALL be treated as an illegal digit (err=1).

Structure
REQ-029 A shared package SHALL hold the state enum typedef (IDLE/CONV/FIN), the constant DIGIT_MAX=9, the constant NUM_DIGITS=4 and the constant VALUE_W=14.
REQ-030 There SHALL be one combinational sub-module, bcd_mac10 (inputs acc[13:0] and digit[3:0]; outputs acc*10+digit truncated to 14 bits and an illegal-digit flag); the FSM and registers SHALL stay in bcd4_to_bin.

Verification
REQ-031 D,C,B,A=1,2,3,4 with start pulse -> value=1234 (0x4D2), err=0, done at edge 5, busy high for 5 cycles.
REQ-032 9,9,9,9 -> value=9999 (0x270F); 0,0,0,0 -> value=0; both with err=0.
REQ-033 A=4'hA, others 0 -> err=1, value=0, done at edge 5; the next legal conversion (0,0,4,2) -> err=0, value=42.
REQ-034 F,F,4,2 -> value=42, err=0 with the macro; err=1, value=0 without it. 4,F,0,1 -> err=1 in both builds.
REQ-035 start re-asserted at edges 2 and 5 of a 1,2,3,4 conversion with inputs changed to 5,6,7,8 -> single result 1234, exactly one done pulse.
REQ-036 rst pulsed low at edge 3 of a conversion -> no done pulse, all outputs 0; a start after release -> a normal result 5 edges later.
